// File: rtl/aes_sched.sv
// rtl/aes_sched.sv - key owner and round-robin scheduler for a shared AES cipher/inverse-cipher pair
//
// Owns the round key: latches a new key, holds kexp_enable for KEXP_CYCLES,
// then grants the encrypt (port 0) and decrypt (port 1) requesters
// round-robin, with one core operation in flight at a time.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   key_valid/key_ready      key handshake, key_in is the offered key
//   req0_valid/ready/data    encrypt request (plaintext)
//   req1_valid/ready/data    decrypt request (ciphertext)
//   rsp0_valid/ready         encrypt response handshake
//   rsp1_valid/ready         decrypt response handshake
//   rsp_data, rsp_err        shared response payload; rsp_err flags a core timeout
//   key_out, kexp_enable     registered key and enable to the key expansion
//   enc_enable, dec_enable   one-cycle start pulses to the cores
//   core_data                operand for the started core, held until the next grant
//   enc_done/enc_result      cipher completion pulse and result
//   dec_done/dec_result      inverse-cipher completion pulse and result
//   key_loaded               a key has been expanded since reset
//   busy                     scheduler is anywhere but IDLE
module aes_sched #(
   parameter int KEY_W       = 128,
   parameter int KEXP_CYCLES = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_valid,
   output logic               key_ready,
   input  logic [KEY_W-1:0]   key_in,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [127:0]       req0_data,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [127:0]       req1_data,
   output logic               rsp0_valid,
   input  logic               rsp0_ready,
   output logic               rsp1_valid,
   input  logic               rsp1_ready,
   output logic [127:0]       rsp_data,
   output logic               rsp_err,
   output logic [KEY_W-1:0]   key_out,
   output logic               kexp_enable,
   output logic               enc_enable,
   output logic               dec_enable,
   output logic [127:0]       core_data,
   input  logic               enc_done,
   input  logic [127:0]       enc_result,
   input  logic               dec_done,
   input  logic [127:0]       dec_result,
   output logic               key_loaded,
   output logic               busy
);

   localparam int KW = (KEXP_CYCLES > 1) ? $clog2(KEXP_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {NOKEY, KEXP, IDLE, RUN_ENC, RUN_DEC, RESP} state_t;

   state_t          state, state_n;
   logic [KW-1:0]   kcnt;
   logic [TW-1:0]   timer;
   logic            rr_last;   // port granted most recently; the other port wins a tie
   logic            op_dec;    // operation in flight / being returned is a decrypt
   logic            key_hs;
   logic            core_done;
   logic            core_tmo;
   logic [127:0]    core_res;

   always_ff @(posedge clk) begin
      if (rst) state <= NOKEY;
      else     state <= state_n;
   end

   always_comb begin
      state_n     = state;
      key_ready   = 1'b0;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      kexp_enable = 1'b0;
      rsp0_valid  = 1'b0;
      rsp1_valid  = 1'b0;
      key_hs      = 1'b0;
      core_done   = 1'b0;
      core_tmo    = 1'b0;
      core_res    = enc_result;
      case (state)
         NOKEY: begin
            key_ready = 1'b1;
            if (key_valid) begin
               key_hs  = 1'b1;
               state_n = KEXP;
            end
         end
         KEXP: begin
            kexp_enable = 1'b1;
            if (kcnt == '0) state_n = IDLE;
         end
         IDLE: begin
            key_ready = 1'b1;
            // A pending key always beats pending requests.
            if (key_valid) begin
               key_hs  = 1'b1;
               state_n = KEXP;
            end else if (req0_valid && (!req1_valid || rr_last)) begin
               req0_ready = 1'b1;
               state_n    = RUN_ENC;
            end else if (req1_valid) begin
               req1_ready = 1'b1;
               state_n    = RUN_DEC;
            end
         end
         RUN_ENC, RUN_DEC: begin
            // Only the started core's done counts; the other is ignored.
            core_done = (state == RUN_ENC) ? enc_done : dec_done;
            core_res  = (state == RUN_ENC) ? enc_result : dec_result;
            core_tmo  = (timer == TW'(TIMEOUT - 1));
            if (core_done || core_tmo) state_n = RESP;
         end
         RESP: begin
            rsp0_valid = !op_dec;
            rsp1_valid = op_dec;
            if (op_dec ? rsp1_ready : rsp0_ready) state_n = IDLE;
         end
         default: state_n = NOKEY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_out    <= '0;
         kcnt       <= '0;
         key_loaded <= 1'b0;
         rr_last    <= 1'b1;
         op_dec     <= 1'b0;
         core_data  <= '0;
         enc_enable <= 1'b0;
         dec_enable <= 1'b0;
         timer      <= '0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
      end else begin
         enc_enable <= 1'b0;
         dec_enable <= 1'b0;
         if (key_hs) begin
            key_out <= key_in;
            kcnt    <= KW'(KEXP_CYCLES - 1);
         end else if (state == KEXP) begin
            if (kcnt == '0) key_loaded <= 1'b1;
            else            kcnt       <= kcnt - 1'b1;
         end
         if (req0_ready) begin
            core_data  <= req0_data;
            rr_last    <= 1'b0;
            op_dec     <= 1'b0;
            enc_enable <= 1'b1;
            timer      <= '0;
         end
         if (req1_ready) begin
            core_data  <= req1_data;
            rr_last    <= 1'b1;
            op_dec     <= 1'b1;
            dec_enable <= 1'b1;
            timer      <= '0;
         end
         if (state == RUN_ENC || state == RUN_DEC) begin
            timer <= timer + 1'b1;
            // A done landing on the timeout cycle still delivers its result.
            if (core_done) begin
               rsp_data <= core_res;
               rsp_err  <= 1'b0;
            end else if (core_tmo) begin
               rsp_data <= '0;
               rsp_err  <= 1'b1;
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
